// File: rtl/seg_display_scan.sv
// seg_display_scan: eight-digit multiplexed seven-segment driver.
// Snapshots one of four 32-bit sources at each frame boundary and scans it
// out as eight hex digits on active-low anode/cathode lines. The decimal
// point on digit <src> identifies which source is being shown.
module seg_display_scan #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        led_cpu_enable,
   input  logic [31:0] led_data_in,
   input  logic [31:0] total_cycles,
   input  logic [31:0] condi_branch_num,
   input  logic [31:0] uncondi_branch_num,
   input  logic [1:0]  disp_sel,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_code,
   output logic [31:0] shown_value,
   output logic        frame_tick
);

   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

   logic [PRE_W-1:0] pre;
   logic [2:0]       dig;
   logic [1:0]       src;
   logic [31:0]      led_hold;
   logic [31:0]      led_next;
   logic [31:0]      sel_value;
   logic             tick;
   logic [3:0]       nibble;
   logic [6:0]       glyph;
   logic             dp_n;

   // Active-low gfedcba pattern for one hex nibble.
   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0:    g = 7'h40;
         4'h1:    g = 7'h79;
         4'h2:    g = 7'h24;
         4'h3:    g = 7'h30;
         4'h4:    g = 7'h19;
         4'h5:    g = 7'h12;
         4'h6:    g = 7'h02;
         4'h7:    g = 7'h78;
         4'h8:    g = 7'h00;
         4'h9:    g = 7'h10;
         4'hA:    g = 7'h08;
         4'hB:    g = 7'h03;
         4'hC:    g = 7'h46;
         4'hD:    g = 7'h21;
         4'hE:    g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

   // Digit-period tick and frame boundary (last tick of digit 7).
   always_comb begin
      tick       = (pre == PRE_LAST);
      frame_tick = tick && (dig == 3'd7) && !rst;
   end

   // LED word as it will stand after this edge; an enable in the boundary
   // cycle reaches shown_value without waiting for led_hold.
   always_comb begin
      led_next = led_cpu_enable ? led_data_in : led_hold;
   end

   // Source multiplexer, only consumed at the frame boundary.
   always_comb begin
      case (disp_sel)
         2'd0:    sel_value = led_next;
         2'd1:    sel_value = total_cycles;
         2'd2:    sel_value = condi_branch_num;
         default: sel_value = uncondi_branch_num;
      endcase
   end

   // Current digit's nibble, glyph and decimal point (built from registers only).
   always_comb begin
      nibble = shown_value[{dig, 2'b00} +: 4];
      glyph  = hex_glyph(nibble);
      dp_n   = (dig != {1'b0, src});
   end

   // Prescaler and digit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         dig <= '0;
      end else if (tick) begin
         pre <= '0;
         dig <= dig + 3'd1;
      end else begin
         pre <= pre + PRE_W'(1);
      end
   end

   // LED hold register, loaded whenever the core qualifies its output.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_hold <= '0;
      end else begin
         led_hold <= led_next;
      end
   end

   // Per-frame snapshot of the selected source and its index.
   always_ff @(posedge clk) begin
      if (rst) begin
         shown_value <= '0;
         src         <= '0;
      end else if (frame_tick) begin
         shown_value <= sel_value;
         src         <= disp_sel;
      end
   end

   // Registered anode and cathode drive; blank while in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_an   <= '1;
         seg_code <= '1;
      end else begin
         seg_an   <= ~(8'b1 << dig);
         seg_code <= {dp_n, glyph};
      end
   end

   // Anodes are either blank or exactly one digit low.
   always @(posedge clk) begin
      if (!rst) begin
         assert ($onehot(~seg_an) || (seg_an == 8'hFF))
            else $error("seg_an not one-hot-low: %h", seg_an);
      end
   end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Eight-digit multiplexed seven-segment display driver sitting directly downstream of the single-cycle CPU core. It consumes the core's LED output (`led_data_in`, `led_cpu_enable`) and its three 32-bit statistics counters. It snapshots the selected 32-bit value once per display frame and scans it out as eight hex digits, using active-low anode and cathode lines.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clock cycles each digit is held; legal range ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, same as the CPU core.
- `rst`  in  1  synchronous active-high reset.
- `led_cpu_enable`  in  1  qualifies `led_data_in`.
- `led_data_in`  in  32  CPU display word.
- `total_cycles`  in  32  CPU cycle counter.
- `condi_branch_num`  in  32  taken conditional branch count.
- `uncondi_branch_num`  in  32  unconditional jump count.
- `disp_sel`  in  2  source select: 0 = LED word, 1 = total_cycles, 2 = condi, 3 = uncondi.
- `seg_an`  out  8  digit anodes, active-low, one-hot-low when scanning.
- `seg_code`  out  8  cathodes, active-low; [6:0] = gfedcba, [7] = dp.
- `shown_value`  out  32  value currently being displayed.
- `frame_tick`  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Prescaler** `pre`: counts 0..SCAN_DIV-1, then wraps. `tick` = (`pre` == SCAN_DIV-1).
- **Digit index** `dig` (3 bits): increments on `tick` and wraps 7→0.
- **Frame boundary** = `tick` && `dig` == 7. `frame_tick` is asserted combinationally in exactly that cycle.
- **LED hold register** `led_hold`: loads `led_data_in` in every cycle where `led_cpu_enable` = 1, and holds otherwise.
- **At a frame boundary only**:
  - `src` <= `disp_sel`.
  - `shown_value` <= the source selected by `disp_sel`: `led_hold` (post-update value, i.e. an enable in the same cycle bypasses to `led_data_in`), `total_cycles`, `condi_branch_num` or `uncondi_branch_num`.
  - Changes on `disp_sel` between boundaries are ignored, so the display never tears mid-frame.
- **Digit content**: digit *i* displays nibble `shown_value`[4i+3:4i]. Digit 0 is the rightmost digit (`seg_an`[0]).
- **Hex decode** (active-low, dp bit set): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- **Decimal point**: lit (bit7 = 0) only on the digit whose index equals `src` (0–3). This identifies the source.
- **Output registers**: `seg_an` <= ~(8'b1 << `dig`); `seg_code` <= decode(nibble[`dig`]) with dp applied.
- **Reset**:
  - `pre`, `dig`, `led_hold`, `shown_value` and `src` are cleared to 0.
  - `seg_an` = 8'hFF and `seg_code` = 8'hFF (blank).
  - `frame_tick` = 0.
  - Reset asserted mid-frame blanks the outputs in the next cycle and restarts the scan at digit 0.

## Timing
- `seg_an` and `seg_code` lag `dig` and `shown_value` by exactly 1 cycle (registered).
- In the first cycle after `rst` deasserts, outputs are still FF/FF. From the second cycle on: `seg_an` = FE and `seg_code` = 40 (digit 0, value 0, dp lit since `src` = 0).
- Each digit is driven for exactly SCAN_DIV cycles. One frame = 8·SCAN_DIV cycles.
- First frame boundary: cycle 8·SCAN_DIV-1 after reset release, counting the release cycle as 0. The new `shown_value` is visible on `shown_value` the next cycle, and on `seg_code` for digit 0 one cycle after that.
- Input sampling:
  - `led_data_in` is sampled on enable.
  - The counters and `disp_sel` are sampled only at the boundary cycle.
  - Values at other times have no effect.
- All arithmetic is unsigned.
- `pre` width = clog2(SCAN_DIV).
- No combinational path from any input to `seg_an` or `seg_code`.

## Test plan
All scenarios use SCAN_DIV = 4.
- **Reset/blank**: hold `rst` 3 cycles, then release → `seg_an` = FF, `seg_code` = FF during reset and the first cycle after; then `seg_an` = FE, `seg_code` = 40 for 4 cycles; then `seg_an` = FD, `seg_code` = C0.
- **LED capture**: pulse `led_cpu_enable` with `led_data_in` = 32'h1234ABCD, `disp_sel` = 0 → after the next `frame_tick`, `shown_value` = 1234ABCD. The digits scan to `seg_code` 21 (D, dp), C6, 83, 88, 99, B0, A4, F9 on anodes FE..7F.
- **Enable gating**: change `led_data_in` to FFFFFFFF with `led_cpu_enable` = 0 → `shown_value` stays 1234ABCD across 3 frames.
- **Source switch mid-frame**: set `total_cycles` = 32'h00000007 and `disp_sel` = 1 at digit 3 → no change until `frame_tick`. Then `shown_value` = 7, digit 0 = F8, digit 1 = 40 (0 with dp), other digits C0.
- **Boundary bypass**: assert `led_cpu_enable` with 32'hCAFEF00D exactly in the frame_tick cycle, with `disp_sel` = 0 → `shown_value` = CAFEF00D on the next cycle.
- **Reset mid-frame**: assert `rst` while digit 5 is displayed → next cycle FF/FF, `shown_value` = 0. The scan restarts at digit 0 and the first `frame_tick` arrives 31 cycles after release.
